segment7_scan: RTL and testbench

Multiplexed N-digit 7-segment display driver for the emulator front panel; successor to the single-digit hex decoder.
Latches a packed hex word plus per-digit decimal-point and blank masks, then time-multiplexes one digit at a time onto a shared segment bus.
Adds PWM brightness, leading-zero blanking, a dead cycle against ghosting, selectable output polarity and a frame pulse.

---
 rtl/segment7_scan.sv | 127 ++++++++++++
 tb/tb_segment7_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/segment7_scan.sv
// Multiplexed N-digit 7-segment scan driver with PWM brightness,
// leading-zero blanking, dead cycle, selectable polarity and frame pulse.
module segment7_scan #(
  parameter int DIGITS         = 8,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Data,
  input  logic [DIGITS-1:0]     Dp,
  input  logic [DIGITS-1:0]     Blank,
  input  logic                  Lzb,
  input  logic [3:0]            Brightness,
  output logic [6:0]            Seg,
  output logic                  SegDp,
  output logic [DIGITS-1:0]     Dig,
  output logic                  Frame
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic [DIGITS-1:0]     blank_q;

  logic [3:0]            nib;
  logic                  dp_i;
  logic                  blank_i;
  logic                  zero_i;
  logic                  lz_i;
  logic                  run;
  logic                  lit;
  logic                  slot_end;
  logic [DIGITS-1:0]     zero_up;
  logic [DIGITS-1:0]     onehot;
  logic [31:0]           lhs;
  logic [31:0]           rhs;

  function automatic logic [6:0] font(input logic [3:0] n);
    unique case (n)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      4'hF: font = 7'h71;
    endcase
  endfunction

  // zero_up[k]: nibbles k..DIGITS-1 are all zero
  always_comb begin
    run     = 1'b1;
    zero_up = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run        = run & (data_q[4*k +: 4] == 4'h0);
      zero_up[k] = run;
    end
    nib     = '0;
    dp_i    = 1'b0;
    blank_i = 1'b1;
    zero_i  = 1'b0;
    onehot  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = data_q[4*k +: 4];
        dp_i      = dp_q[k];
        blank_i   = blank_q[k];
        zero_i    = zero_up[k];
        onehot[k] = 1'b1;
      end
    end
  end

  assign lz_i     = Lzb && (idx != '0) && zero_i;
  assign lhs      = 32'(presc) * 32'd15;
  assign rhs      = 32'(Brightness) * 32'(PRESCALE);
  assign slot_end = (presc == PLAST);
  assign lit      = (presc != '0) && (lhs < rhs)
                    && !blank_i && !lz_i;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      presc   <= '0;
      idx     <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '1;
      Seg     <= {7{SEG_ACTIVE_LOW}};
      SegDp   <= SEG_ACTIVE_LOW;
      Dig     <= {DIGITS{DIG_ACTIVE_LOW}};
      Frame   <= 1'b0;
    end else begin
      if (Load) begin
        data_q  <= Data;
        dp_q    <= Dp;
        blank_q <= Blank;
      end
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) begin
        idx <= (idx == ILAST) ? '0 : idx + 1'b1;
      end
      Frame <= slot_end && (idx == ILAST);
      Seg   <= (lit ? font(nib) : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
      SegDp <= (lit & dp_i) ^ SEG_ACTIVE_LOW;
      Dig   <= (lit ? onehot : '0) ^ {DIGITS{DIG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_segment7_scan.sv
// Scoreboard bench for segment7_scan: two instances (active-high, fast
// scan and active-low, slow scan) checked against a slot-arithmetic model.
module tb_segment7_scan;

  localparam int D  = 4;
  localparam int PA = 4;
  localparam int PB = 16;
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Load;
  logic        Lzb;
  logic [15:0] Data;
  logic [3:0]  Dp;
  logic [3:0]  Blank;
  logic [3:0]  Brightness;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic        fr_a, fr_b;
  logic [3:0]  dig_a, dig_b;

  always #5 Clk = ~Clk;

  segment7_scan #(
    .DIGITS(D), .PRESCALE(PA),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) u_a (
    .Clk(Clk), .Rst_n(Rst_n), .Load(Load), .Data(Data),
    .Dp(Dp), .Blank(Blank), .Lzb(Lzb), .Brightness(Brightness),
    .Seg(seg_a), .SegDp(dp_a), .Dig(dig_a), .Frame(fr_a)
  );

  segment7_scan #(
    .DIGITS(D), .PRESCALE(PB),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_b (
    .Clk(Clk), .Rst_n(Rst_n), .Load(Load), .Data(Data),
    .Dp(Dp), .Blank(Blank), .Lzb(Lzb), .Brightness(Brightness),
    .Seg(seg_b), .SegDp(dp_b), .Dig(dig_b), .Frame(fr_b)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       fr;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          k;
  logic [15:0] sh_data;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_blank;

  // k = edges since reset; slot and digit follow from plain division
  function automatic obs_t model(int plen, bit inv_seg, bit inv_dig);
    obs_t o;
    int p, i;
    bit lz, on;
    logic [3:0] nib;
    p   = k % plen;
    i   = (k / plen) % D;
    nib = 4'((sh_data >> (4 * i)) & 16'hF);
    lz  = Lzb && (i != 0) && ((sh_data >> (4 * i)) == 16'h0);
    on  = (p != 0) && (p * 15 < int'(Brightness) * plen)
          && !sh_blank[i] && !lz && Rst_n;
    o.seg = on ? FONT[nib] : 7'h00;
    o.dp  = on && sh_dp[i];
    o.dig = on ? 4'(1 << i) : 4'h0;
    o.fr  = Rst_n && (p == plen - 1) && (i == D - 1);
    if (inv_seg) begin
      o.seg = ~o.seg;
      o.dp  = ~o.dp;
    end
    if (inv_dig) o.dig = ~o.dig;
    return o;
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("dut_a {seg,dp,dig,frame}",
            16'({seg_a, dp_a, dig_a, fr_a}), 16'(e.a));
        chk("dut_b {seg,dp,dig,frame}",
            16'({seg_b, dp_b, dig_b, fr_b}), 16'(e.b));
      end
    end
  end

  task automatic step();
    exp_t e;
    e.a = model(PA, 1'b0, 1'b0);
    e.b = model(PB, 1'b1, 1'b1);
    sbq.push_back(e);
    @(posedge Clk);
    if (!Rst_n) begin
      k        = 0;
      sh_data  = '0;
      sh_dp    = '0;
      sh_blank = '1;
    end else begin
      if (Load) begin
        sh_data  = Data;
        sh_dp    = Dp;
        sh_blank = Blank;
      end
      k++;
    end
    @(negedge Clk);
    #1;
  endtask

  task automatic load(logic [15:0] d, logic [3:0] p, logic [3:0] b);
    Data  = d;
    Dp    = p;
    Blank = b;
    Load  = 1'b1;
    step();
    Load  = 1'b0;
  endtask

  initial begin
    int fa, fb;
    Rst_n = 1'b0; Load = 1'b0; Lzb = 1'b0;
    Data = '0; Dp = '0; Blank = '0; Brightness = 4'd15;
    k = 0; sh_data = '0; sh_dp = '0; sh_blank = '1;
    @(negedge Clk);
    #1;
    step();
    step();
    Rst_n = 1'b1;

    load(16'h12AF, 4'b0010, 4'b0000);
    fa = 0;
    fb = 0;
    repeat (64) begin
      step();
      fa += int'(fr_a);
      fb += int'(fr_b);
    end
    chk("frame_count_a", 16'(fa), 16'd4);
    chk("frame_count_b", 16'(fb), 16'd1);

    Lzb = 1'b1;
    load(16'h0030, 4'b0000, 4'b0000);
    repeat (64) step();
    load(16'h0000, 4'b1111, 4'b0000);
    repeat (64) step();

    Lzb = 1'b0;
    Brightness = 4'd4;
    load(16'h4321, 4'b1111, 4'b0100);
    repeat (64) step();

    Brightness = 4'd15;
    load(16'h0008, 4'b0000, 4'b0000);
    repeat (32) step();

    load(16'h5678, 4'b0101, 4'b0000);
    for (int n = 0; n < 100; n++) begin
      if (((k / PA) % D == 2) && (k % PA == 2)) break;
      step();
    end
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    repeat (40) step();

    load(16'h1111, 4'b0000, 4'b0000);
    for (int n = 0; n < 8; n++) begin
      if (k % PA == PA - 1) break;
      step();
    end
    load(16'h9ABC, 4'b1000, 4'b0000);
    repeat (20) step();

    repeat (2000) begin
      Load       = ($urandom_range(0, 7) == 0);
      Data       = 16'($urandom) >> (4 * $urandom_range(0, 4));
      Dp         = 4'($urandom);
      Blank      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      Lzb        = 1'($urandom_range(0, 1));
      Brightness = 4'($urandom);
      Rst_n      = ($urandom_range(0, 199) != 0);
      step();
    end
    Rst_n = 1'b1;
    Load  = 1'b0;
    repeat (4) step();
    chk("scoreboard_drained", 16'(sbq.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
